// File: rtl/inst_fetch_if.sv
// Instruction-SRAM handshake bus between the fetch stage (master) and the
// instruction memory (slave). Only one read is ever outstanding.
interface inst_fetch_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;

  modport master (
    output inst_req,
    output inst_addr,
    input  inst_addr_ok,
    input  inst_data_ok,
    input  inst_rdata
  );

  modport slave (
    input  inst_req,
    input  inst_addr,
    output inst_addr_ok,
    output inst_data_ok,
    output inst_rdata
  );
endinterface

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: issues one read per PC on the SRAM handshake bus,
// holds the PC while a read is outstanding, buffers a completed fetch while
// IF/ID is stalled, and swallows in-flight responses after a flush.
module inst_fetch #(
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         pc_i,
  input  logic [5:0]          stall,
  input  logic                flush,
  inst_fetch_if.master        bus,
  output logic                if_valid,
  output logic [31:0]         if_pc,
  output logic [31:0]         if_inst,
  output logic                if_adel,
  output logic                stallreq
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ     = 3'd1,
    WAIT    = 3'd2,
    DONE    = 3'd3,
    DISCARD = 3'd4
  } state_t;

  state_t      state, state_next;
  logic [31:0] req_pc, req_pc_next;
  logic [31:0] buf_inst, buf_inst_next;
  logic        buf_adel, buf_adel_next;

  logic misaligned;
  assign misaligned = (pc_i[1:0] != 2'b00);

  // Only stall[1] (IF/ID hold) matters to this stage.
  logic stall_unused;
  assign stall_unused = &{1'b0, stall[5:2], stall[0]};

  // State and fetch-buffer registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      req_pc   <= 32'h0;
      buf_inst <= 32'h0;
      buf_adel <= 1'b0;
    end else begin
      state    <= state_next;
      req_pc   <= req_pc_next;
      buf_inst <= buf_inst_next;
      buf_adel <= buf_adel_next;
    end
  end

  // Next-state and combinational bus/pipeline outputs; flush takes priority.
  always_comb begin
    state_next    = state;
    req_pc_next   = req_pc;
    buf_inst_next = buf_inst;
    buf_adel_next = buf_adel;
    bus.inst_req  = 1'b0;
    bus.inst_addr = 32'h0;
    if_valid      = 1'b0;
    if_pc         = 32'h0;
    if_inst       = 32'h0;
    if_adel       = 1'b0;
    stallreq      = 1'b0;

    case (state)
      IDLE: begin
        stallreq   = ~flush;
        state_next = REQ;
      end

      REQ: begin
        if (misaligned) begin
          // Address error completes without touching the bus.
          if (!flush) begin
            if_valid = 1'b1;
            if_pc    = pc_i;
            if_inst  = NOP_INST;
            if_adel  = 1'b1;
            if (stall[1]) begin
              state_next    = DONE;
              req_pc_next   = pc_i;
              buf_inst_next = NOP_INST;
              buf_adel_next = 1'b1;
            end
          end
        end else begin
          bus.inst_req  = 1'b1;
          bus.inst_addr = pc_i;
          stallreq      = ~flush;
          if (bus.inst_addr_ok) begin
            req_pc_next = pc_i;
            // An accepted request under flush still owes us a response.
            state_next  = flush ? DISCARD : WAIT;
          end
        end
      end

      WAIT: begin
        if (flush) begin
          state_next = bus.inst_data_ok ? REQ : DISCARD;
        end else if (bus.inst_data_ok) begin
          if_valid = 1'b1;
          if_pc    = req_pc;
          if_inst  = bus.inst_rdata;
          if (stall[1]) begin
            state_next    = DONE;
            buf_inst_next = bus.inst_rdata;
            buf_adel_next = 1'b0;
          end else begin
            state_next = REQ;
          end
        end else begin
          stallreq = 1'b1;
        end
      end

      DONE: begin
        if (flush) begin
          state_next = REQ;
        end else begin
          if_valid = 1'b1;
          if_pc    = req_pc;
          if_inst  = buf_inst;
          if_adel  = buf_adel;
          if (!stall[1]) state_next = REQ;
        end
      end

      DISCARD: begin
        stallreq = ~flush;
        if (bus.inst_data_ok) state_next = REQ;
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    // While reset is held the outputs show the idle values regardless of bus inputs.
    if (reset) begin
      bus.inst_req  = 1'b0;
      bus.inst_addr = 32'h0;
      if_valid      = 1'b0;
      if_pc         = 32'h0;
      if_inst       = 32'h0;
      if_adel       = 1'b0;
      stallreq      = 1'b1;
    end
  end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction-fetch stage sitting directly downstream of the program counter: takes the current PC, issues one read at a time on the instruction-SRAM handshake bus, and presents the fetched word with its PC to the IF/ID register. It holds the PC via a stall request while a fetch is outstanding, buffers a returned word while the pipeline is stalled, and discards in-flight responses on flush. One outstanding transaction at most.

## Interface
Parameters:
- NOP_INST, 32'h0000_0000, word delivered on `if_inst` for a misaligned-PC completion

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- pc_i  in  32  current PC from the PC stage
- stall  in  6  pipeline stall vector; stall[1]=1 means IF/ID cannot accept
- flush  in  1  exception/eret flush; PC loads new_pc on the same edge
- inst_req  out  1  read request to instruction memory
- inst_addr  out  32  request address, equal to pc_i while inst_req=1
- inst_addr_ok  in  1  address accepted this cycle (valid only with inst_req=1)
- inst_data_ok  in  1  read data valid this cycle
- inst_rdata  in  32  read data
- if_valid  out  1  completed fetch presented this cycle
- if_pc  out  32  PC of presented instruction
- if_inst  out  32  presented instruction
- if_adel  out  1  presented fetch had misaligned PC (pc_i[1:0]!=0)
- stallreq  out  1  request to hold the PC (to stall controller)

## Operation
- States: IDLE, REQ, WAIT, DONE, DISCARD. Registers: state, req_pc[31:0], buf_inst[31:0], buf_adel.
- Reset: state=IDLE, req_pc=0, buf_inst=0, buf_adel=0. Combinational outputs during reset: inst_req=0, if_valid=0, if_adel=0, stallreq=1, if_pc=0, if_inst=0.
- IDLE: inst_req=0, stallreq=1; -> REQ next edge unconditionally.
- REQ: if pc_i[1:0]!=0: no request; completion cycle with if_pc=pc_i, if_inst=NOP_INST, if_adel=1. Otherwise inst_req=1, inst_addr=pc_i, stallreq=1; on inst_addr_ok latch req_pc=pc_i, -> WAIT; else stay.
- WAIT: inst_req=0. On inst_data_ok: completion cycle, if_pc=req_pc, if_inst=inst_rdata, if_adel=0. Else stallreq=1, stay.
- Completion cycle (from REQ-misaligned or WAIT+data_ok): if_valid=1, stallreq=0. If stall[1]=0 -> REQ (PC advances same edge). If stall[1]=1 -> DONE, latch buf_inst/buf_adel and req_pc (from pc_i when misaligned).
- DONE: if_valid=1, if_pc=req_pc, if_inst=buf_inst, if_adel=buf_adel, stallreq=0, inst_req=0; -> REQ when stall[1]=0, else stay.
- DISCARD: inst_req=0, if_valid=0, stallreq=1; on inst_data_ok (data dropped) -> REQ.
- Flush has top priority; in a flush cycle if_valid=0 and stallreq=0:
  - REQ, no addr_ok: stay REQ (next cycle addresses new_pc). REQ with addr_ok same cycle: -> DISCARD.
  - WAIT without data_ok: -> DISCARD. WAIT with data_ok same cycle: drop data, -> REQ.
  - DONE: drop buffer, -> REQ. DISCARD: stays DISCARD unless data_ok (-> REQ). IDLE: -> REQ.
- Reset mid-transaction returns to IDLE; the memory is reset by the same signal, so no stale response is expected.

## Timing
- inst_req, inst_addr, if_* and stallreq are combinational from state/registers/bus inputs; no path from stall to stallreq (no loop through stall controller).
- Best case (addr_ok with request, data_ok next cycle): one instruction every 2 cycles; first completion at cycle 3 after reset deassert (IDLE, REQ, WAIT+data_ok).
- addr_ok same-cycle acceptance required; data_ok may arrive any later cycle, never in the addr_ok cycle.
- Never more than one transaction outstanding; inst_req is 0 in WAIT, DONE, DISCARD.

## Test plan
- Zero-wait memory, pc 0xBFC0_0000 sequential: req addresses 0xBFC00000, 0xBFC00004, ...; if_valid every 2nd cycle, if_inst matches memory, stallreq=0 only on completion cycles.
- addr_ok delayed 3 cycles, data_ok delayed 4: inst_req held 4 cycles with constant inst_addr, stallreq=1 throughout, single completion with correct if_pc.
- stall[1]=1 for 5 cycles at completion: DONE holds if_pc/if_inst constant, if_valid=1, no new inst_req; request for pc+4 issued cycle after stall[1] drops.
- flush in WAIT before data_ok, new_pc=0xBFC0_0380: DISCARD; stale data_ok produces if_valid=0; next inst_addr=0xBFC00380.
- flush coincident with data_ok, and flush coincident with addr_ok: first drops data and requests new PC next cycle; second enters DISCARD and waits for the response.
- pc_i=0x8000_0002: no inst_req, if_valid=1, if_adel=1, if_inst=NOP_INST, if_pc=0x80000002 in that cycle; reset asserted in WAIT returns all outputs to reset values immediately.
